// File: rtl/keymap_ctrl.sv
// HID keycode report to per-player action vectors {kick, jump, right, left}, with a kick timing FSM per player.
// Optional 2-report hold filter on left/right/jump: define KEYMAP_HOLD_FILTER_EN.
module keymap_ctrl #(
    parameter logic [7:0] P1_LEFT         = 8'h04,
    parameter logic [7:0] P1_RIGHT        = 8'h07,
    parameter logic [7:0] P1_JUMP         = 8'h1A,
    parameter logic [7:0] P1_KICK         = 8'h16,
    parameter logic [7:0] P2_LEFT         = 8'h50,
    parameter logic [7:0] P2_RIGHT        = 8'h4F,
    parameter logic [7:0] P2_JUMP         = 8'h52,
    parameter logic [7:0] P2_KICK         = 8'h51,
    parameter int         KICK_FRAMES     = 8,
    parameter int         COOLDOWN_FRAMES = 12
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    input  logic [31:0] keycodes,
    input  logic        goal_reset,
    output logic [7:0]  p1_action,
    output logic [7:0]  p2_action
);

    typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN, WAIT_REL} kick_state_t;

    // Bit order per player: left, right, jump, kick.
    localparam logic [7:0] KEY_CODE [8] = '{P1_LEFT, P1_RIGHT, P1_JUMP, P1_KICK,
                                            P2_LEFT, P2_RIGHT, P2_JUMP, P2_KICK};

    logic             rollover;
    logic [7:0]       raw;
    logic [7:0]       held_reg;
    logic [7:0]       present;
    logic [1:0][2:0]  filt;
    logic [1:0][3:0]  act;

    always_comb begin
        rollover = 1'b0;
        raw      = '0;
        for (int s = 0; s < 4; s++) begin
            if (keycodes[8*s +: 8] == 8'h01)
                rollover = 1'b1;
            for (int k = 0; k < 8; k++)
                if (keycodes[8*s +: 8] == KEY_CODE[k])
                    raw[k] = 1'b1;
        end
    end

    // A rollover-error report is discarded; the last accepted key set stands in for it.
    assign present = rollover ? held_reg : raw;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            held_reg <= '0;
        else if (!rollover)
            held_reg <= raw;
    end

`ifdef KEYMAP_HOLD_FILTER_EN
    logic [1:0][2:0] prev_reg;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            prev_reg <= '0;
        else if (!rollover)
            prev_reg <= {held_reg[6:4], held_reg[2:0]};
    end
`endif

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_player
            kick_state_t state_reg;
            logic [7:0]  cnt_reg;
            logic [2:0]  move_reg;
            logic        kick_key;

            assign kick_key = present[4*gi+3];

`ifdef KEYMAP_HOLD_FILTER_EN
            // During an error frame the filter repeats its last accepted verdict.
            assign filt[gi] = rollover ? (held_reg[4*gi +: 3] & prev_reg[gi])
                                       : (raw[4*gi +: 3] & held_reg[4*gi +: 3]);
`else
            assign filt[gi] = present[4*gi +: 3];
`endif

            always_ff @(posedge frame_clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                    move_reg  <= '0;
                end else if (goal_reset) begin
                    state_reg <= kick_key ? WAIT_REL : IDLE;
                    cnt_reg   <= '0;
                    move_reg  <= '0;
                end else begin
                    move_reg <= {filt[gi][2],
                                 filt[gi][1] & ~present[4*gi],
                                 filt[gi][0] & ~present[4*gi+1]};
                    case (state_reg)
                        IDLE: begin
                            if (kick_key) begin
                                state_reg <= ACTIVE;
                                cnt_reg   <= 8'(KICK_FRAMES - 1);
                            end
                        end
                        ACTIVE: begin
                            if (cnt_reg != 8'd0) begin
                                cnt_reg <= cnt_reg - 8'd1;
                            end else begin
                                state_reg <= COOLDOWN;
                                cnt_reg   <= 8'(COOLDOWN_FRAMES - 1);
                            end
                        end
                        COOLDOWN: begin
                            if (cnt_reg != 8'd0)
                                cnt_reg <= cnt_reg - 8'd1;
                            else
                                state_reg <= kick_key ? WAIT_REL : IDLE;
                        end
                        WAIT_REL: begin
                            if (!kick_key)
                                state_reg <= IDLE;
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            assign act[gi] = {state_reg == ACTIVE, move_reg};
        end
    endgenerate

    assign p1_action = {4'b0000, act[0]};
    assign p2_action = {4'b0000, act[1]};

endmodule

// File: tb/tb_keymap_ctrl.sv
// Randomized self-checking bench for keymap_ctrl against a timing-based behavioural model.
// Honours KEYMAP_HOLD_FILTER_EN when defined at compile time.
module tb_keymap_ctrl;

    localparam int K = 8;
    localparam int C = 12;
`ifdef KEYMAP_HOLD_FILTER_EN
    localparam int SETTLE = 2;
`else
    localparam int SETTLE = 1;
`endif

    logic        frame_clk = 1'b0;
    logic        Reset_n   = 1'b0;
    logic        goal_reset = 1'b0;
    logic [31:0] keycodes  = '0;
    logic [7:0]  p1_action;
    logic [7:0]  p2_action;

    keymap_ctrl #(.KICK_FRAMES(K), .COOLDOWN_FRAMES(C)) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .keycodes  (keycodes),
        .goal_reset(goal_reset),
        .p1_action (p1_action),
        .p2_action (p2_action)
    );

    always #5 frame_clk = ~frame_clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic [7:0] codes [8] = '{8'h04, 8'h07, 8'h1A, 8'h16, 8'h50, 8'h4F, 8'h52, 8'h51};

    // Model: kick expressed as "high through frame active_until", re-armed by a release seen
    // no earlier than frame ready.
    logic [7:0] m_held, m_prev;
    int         n;
    bit         armed [2];
    int         ready [2];
    int         active_until [2];
    logic [7:0] exp_act [2];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] raw_of(input logic [31:0] kc);
        logic [7:0] r;
        r = '0;
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 8; k++)
                if (kc[8*s +: 8] == codes[k]) r[k] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_held = '0;
        m_prev = '0;
        for (int p = 0; p < 2; p++) begin
            armed[p]        = 1'b1;
            ready[p]        = 0;
            active_until[p] = -1000;
            exp_act[p]      = 8'h00;
        end
    endtask

    task automatic model_step(input logic [31:0] kc, input logic gr);
        logic       err;
        logic [7:0] raw, pres, filt;
        logic       l, r, kk;
        int         b;
        err = 1'b0;
        for (int s = 0; s < 4; s++)
            if (kc[8*s +: 8] == 8'h01) err = 1'b1;
        raw  = raw_of(kc);
        pres = err ? m_held : raw;
`ifdef KEYMAP_HOLD_FILTER_EN
        filt = err ? (m_held & m_prev) : (raw & m_held);
`else
        filt = pres;
`endif
        if (!err) begin
            m_prev = m_held;
            m_held = raw;
        end
        for (int p = 0; p < 2; p++) begin
            b  = 4 * p;
            l  = pres[b];
            r  = pres[b+1];
            kk = pres[b+3];
            if (gr) begin
                exp_act[p]      = 8'h00;
                active_until[p] = n - 1;
                if (kk) begin
                    armed[p] = 1'b0;
                    ready[p] = n + 1;
                end else begin
                    armed[p] = 1'b1;
                end
            end else begin
                if (!kk && n >= ready[p]) armed[p] = 1'b1;
                if (kk && armed[p]) begin
                    active_until[p] = n + K - 1;
                    ready[p]        = n + K + C;
                    armed[p]        = 1'b0;
                end
                exp_act[p] = {4'b0000, n <= active_until[p], filt[b+2],
                              filt[b+1] & ~l, filt[b] & ~r};
            end
        end
        n++;
    endtask

    task automatic step(input logic [31:0] kc, input logic gr);
        keycodes   = kc;
        goal_reset = gr;
        @(posedge frame_clk);
        #1;
        model_step(kc, gr);
        $display("frame %0d kc=%h gr=%b p1=%h p2=%h", n, kc, gr, p1_action, p2_action);
    endtask

    always @(negedge frame_clk) begin
        if (check_en && Reset_n) begin
            chk("p1_model", p1_action, exp_act[0]);
            chk("p2_model", p2_action, exp_act[1]);
        end
    end

    initial begin
        logic [31:0] kc;
        int          slot, pick;
        logic [7:0]  code;
        n = 0;
        model_reset();

        keycodes = 32'h0000_0004;
        repeat (3) @(posedge frame_clk);
        #1;
        chk("reset_p1", p1_action, 8'h00);
        chk("reset_p2", p2_action, 8'h00);
        Reset_n  = 1'b1;
        check_en = 1'b1;

        repeat (SETTLE) step(32'h0000_0004, 1'b0);
        chk("p1_left", p1_action, 8'h01);
        step(32'h0000_0704, 1'b0);
        chk("p1_cancel", p1_action, 8'h00);
        repeat (SETTLE) step(32'h0000_4F00, 1'b0);
        chk("p2_right", p2_action, 8'h02);
        repeat (SETTLE) step(32'h0000_0052, 1'b0);
        chk("p2_jump", p2_action, 8'h04);
        step(32'h0101_0101, 1'b0);
        chk("p2_rollover_hold", p2_action, 8'h04);
        step(32'h0000_0000, 1'b0);
        chk("idle", p2_action, 8'h00);

        for (int i = 1; i <= 40; i++) begin
            step(32'h0000_0016, 1'b0);
            chk("kick_hold", {7'd0, p1_action[3]}, {7'd0, i <= K});
        end
        step(32'h0000_0000, 1'b0);
        chk("kick_release", p1_action, 8'h00);
        step(32'h0000_0016, 1'b0);
        chk("kick_repress", p1_action, 8'h08);
        repeat (25) step(32'h0000_0000, 1'b0);

        repeat (3) step(32'h0000_0016, 1'b0);
        chk("kick_active3", p1_action, 8'h08);
        step(32'h0000_0016, 1'b1);
        chk("goal_reset", p1_action, 8'h00);
        for (int i = 0; i < 30; i++) begin
            step(32'h0000_0016, 1'b0);
            chk("goal_no_kick", {7'd0, p1_action[3]}, 8'h00);
        end
        step(32'h0000_0000, 1'b0);
        step(32'h0000_0016, 1'b0);
        chk("goal_rekick", p1_action, 8'h08);

        step(32'h0000_5116, 1'b0);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_p1", p1_action, 8'h00);
        chk("async_p2", p2_action, 8'h00);
        model_reset();
        keycodes = 32'h0;
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(32'h0000_0000, 1'b0);
            chk("no_resume", p1_action | p2_action, 8'h00);
        end

`ifdef KEYMAP_HOLD_FILTER_EN
        step(32'h0000_001A, 1'b0);
        chk("filt_one", p1_action, 8'h00);
        step(32'h0000_0000, 1'b0);
        step(32'h0000_001A, 1'b0);
        step(32'h0000_001A, 1'b0);
        chk("filt_two", p1_action, 8'h04);
        step(32'h0000_0000, 1'b0);
        chk("filt_release", p1_action, 8'h00);
`else
        step(32'h0000_001A, 1'b0);
        chk("jump_level", p1_action, 8'h04);
        step(32'h0000_0000, 1'b0);
        chk("jump_release", p1_action, 8'h00);
`endif

        kc = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                slot = $urandom_range(0, 3);
                pick = $urandom_range(0, 15);
                if (pick < 8)       code = codes[pick];
                else if (pick < 12) code = 8'h00;
                else if (pick == 12) code = 8'h01;
                else                code = 8'($urandom);
                kc[8*slot +: 8] = code;
            end
            step(kc, $urandom_range(0, 59) == 0);
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
